rgb_color_classifier: RTL and testbench
=======================================

# rgb_color_classifier

Pipelined, parametrised successor to the single-colour RGB classifier in the camera path. For each pixel it computes the HSV terms and tests them against NUM_COLORS independently programmable colour windows. It passes RGB through, blanking pixels outside the active window. It also accumulates a per-colour pixel count and bounding box over each frame, for the pong paddle/ball trackers downstream.

## Interface
Parameters:
- NUM_COLORS, 2, number of colour classes (1..8)
- H_ACT, 480, active rows
- W_ACT, 640, active columns
- CNT_W, 19, per-colour pixel-count width

Ports (SW = max(1, clog2(NUM_COLORS))):
- clk  in  1  single clock for the block
- reset  in  1  synchronous, active-high
- i_valid  in  1  pixel qualifier
- i_R, i_G, i_B  in  8 each  raw pixel
- i_row, i_col  in  13 each  pixel coordinates
- cfg_we  in  1  config write strobe
- cfg_sel  in  SW  colour index
- cfg_addr  in  2  field: 0 hue_lo, 1 hue_hi, 2 v_min, 3 s_shift
- cfg_data  in  8  field value; hue fields use [5:0], signed, units of D/4; s_shift uses [2:0]
- o_valid  out  1  delayed i_valid
- o_R, o_G, o_B  out  8 each  pass-through pixel, 0 outside the active window
- o_row, o_col  out  13 each  delayed coordinates
- o_color  out  NUM_COLORS  per-class match bit
- stat_valid  out  1  one-cycle pulse when frame stats are latched
- stat_count  out  NUM_COLORS*CNT_W  matched pixels per class
- stat_rmin, stat_rmax, stat_cmin, stat_cmax  out  NUM_COLORS*13 each  bounding box per class

## Operation
- Colour terms: MX = max(R,G,B), MN = min, D = MX−MN, V = MX, S = D.
- Hue numerator H is signed 14-bit:
  - MX==R: H = G−B
  - else MX==G: H = 2D + (B−R)
  - else: H = 4D + (R−G)
  - Ties resolve R before G before B.
- Class k matches when all of these hold:
  - pixel is inside the window (row < H_ACT and col < W_ACT)
  - lo_k < H < hi_k, with lo_k = (hue_lo_k × D) >>> 2 and hi_k = (hue_hi_k × D) >>> 2; products are signed 14-bit, shift is arithmetic, comparisons are strict
  - V ≥ v_min_k
  - S > (V >> s_shift_k)
- Outside the window, o_R/o_G/o_B = 0 and o_color = 0.
- Config uses shadow + active register banks.
  - cfg_we writes the shadow bank only.
  - Shadow is copied to active at end-of-frame (EOF).
  - A write in the EOF cycle lands in shadow; active receives the pre-write shadow value.
  - cfg_sel ≥ NUM_COLORS: write is ignored.
- Reset values for both banks:
  - class 0 (red): lo 0, hi 1, v_min 65, s_shift 1
  - class 1 (green): lo 7, hi 9, v_min 65, s_shift 2
  - classes ≥2: lo 0, hi 0, v_min 255, s_shift 0 (never match)
- Stats accumulate per class, only for stage-4 pixels with o_valid=1 and o_color[k]=1:
  - count += 1
  - rmin/rmax/cmin/cmax = running min/max of row/col
  - Accumulator idle values: count 0, rmin/cmin 8191, rmax/cmax 0.
- EOF: stage-4 pixel with o_valid=1, o_row = H_ACT−1 and o_col = W_ACT−1. In that cycle:
  - the EOF pixel's contribution is included in the latched stats
  - accumulators return to idle values
  - active config is reloaded from shadow
  - stat_valid pulses the next cycle
- Empty class at EOF reports count 0, rmin/cmin 8191, rmax/cmax 0.
- Count saturates at 2^CNT_W−1.

## Timing
- Pipeline is 4 stages, fixed latency 4 cycles from i_* to o_*; throughput is one pixel per clock.
  - S1: register MX, MN, argmax, and pass-through data.
  - S2: D and H.
  - S3: lo/hi products and V shift.
  - S4: compares, window test, output registers.
- The valid bit travels with data; bubbles (i_valid=0) propagate with o_color forced 0.
- stat_* registers hold until the next EOF. stat_valid is high for exactly one cycle, at EOF+1.
- Reset (any cycle, including mid-frame):
  - all pipeline valids, o_*, o_color and stat_valid go to 0
  - stat_* go to idle values
  - accumulators are cleared
  - config banks return to reset values
  - no stat_valid pulse for the interrupted frame
- Config takes effect for pixels entering S3 after the EOF copy. Pixels already in flight use the old values; this is acceptable because EOF has no following active pixels.

## Test plan
- After reset, pixel (200,40,20) at row 10 col 10 with valid → 4 cycles later o_color=2'b01, o_R/G/B=200/40/20, o_row=10, o_col=10.
- Pixel (30,200,60) → H=370, lo=297, hi=382 → o_color=2'b10. Pixel (200,20,20), where H=0 fails the strict lower bound → o_color=0.
- Pixel (200,40,20) at row 480 col 5 → o_R/G/B=0, o_color=0, o_valid=1.
- Full 640×480 frame with red at (10,10), (12,30), (40,5), all else black:
  - stat_valid pulses once, one cycle after the (479,639) output cycle
  - count0=3, rmin0=10, rmax0=40, cmin0=5, cmax0=30
  - class 1: count 0, mins 8191, maxes 0
- Mid-frame cfg write class0 hue_hi=0 → red still detected for the rest of this frame, not detected in the next frame. A write issued exactly in the EOF cycle appears only after the following EOF.
- Reset asserted mid-frame after 2 red pixels, then a full clean frame with 1 red pixel:
  - no stat_valid before that frame's EOF
  - then count0=1

Source files
------------

// File: rtl/rgb_color_classifier.sv
// Four-stage HSV colour classifier with NUM_COLORS programmable hue/value/saturation
// windows, active-window blanking and per-class frame statistics (count + bounding box).
module rgb_color_classifier #(
    parameter int  NUM_COLORS = 2,
    parameter int  H_ACT      = 480,
    parameter int  W_ACT      = 640,
    parameter int  CNT_W      = 19,
    localparam int SW         = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_valid,
    input  logic [7:0]                  i_R,
    input  logic [7:0]                  i_G,
    input  logic [7:0]                  i_B,
    input  logic [12:0]                 i_row,
    input  logic [12:0]                 i_col,
    input  logic                        cfg_we,
    input  logic [SW-1:0]               cfg_sel,
    input  logic [1:0]                  cfg_addr,
    input  logic [7:0]                  cfg_data,
    output logic                        o_valid,
    output logic [7:0]                  o_R,
    output logic [7:0]                  o_G,
    output logic [7:0]                  o_B,
    output logic [12:0]                 o_row,
    output logic [12:0]                 o_col,
    output logic [NUM_COLORS-1:0]       o_color,
    output logic                        stat_valid,
    output logic [NUM_COLORS*CNT_W-1:0] stat_count,
    output logic [NUM_COLORS*13-1:0]    stat_rmin,
    output logic [NUM_COLORS*13-1:0]    stat_rmax,
    output logic [NUM_COLORS*13-1:0]    stat_cmin,
    output logic [NUM_COLORS*13-1:0]    stat_cmax
);

    localparam logic [12:0] COORD_MAX = 13'h1FFF;

    // Reset values: class 0 red, class 1 green, the rest never match.
    function automatic logic [5:0] rst_lo(input int k);
        return (k == 1) ? 6'd7 : 6'd0;
    endfunction
    function automatic logic [5:0] rst_hi(input int k);
        return (k == 0) ? 6'd1 : (k == 1) ? 6'd9 : 6'd0;
    endfunction
    function automatic logic [7:0] rst_vmin(input int k);
        return (k < 2) ? 8'd65 : 8'd255;
    endfunction
    function automatic logic [2:0] rst_shf(input int k);
        return (k == 0) ? 3'd1 : (k == 1) ? 3'd2 : 3'd0;
    endfunction

    logic [5:0] lo_sh   [NUM_COLORS];
    logic [5:0] hi_sh   [NUM_COLORS];
    logic [7:0] vmin_sh [NUM_COLORS];
    logic [2:0] shf_sh  [NUM_COLORS];
    logic [5:0] lo_act  [NUM_COLORS];
    logic [5:0] hi_act  [NUM_COLORS];
    logic [7:0] vmin_act[NUM_COLORS];
    logic [2:0] shf_act [NUM_COLORS];

    logic eof;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_COLORS; k++) begin
                lo_sh[k]    <= rst_lo(k);
                hi_sh[k]    <= rst_hi(k);
                vmin_sh[k]  <= rst_vmin(k);
                shf_sh[k]   <= rst_shf(k);
                lo_act[k]   <= rst_lo(k);
                hi_act[k]   <= rst_hi(k);
                vmin_act[k] <= rst_vmin(k);
                shf_act[k]  <= rst_shf(k);
            end
        end else begin
            // The copy reads shadow before this cycle's write lands.
            if (eof) begin
                for (int k = 0; k < NUM_COLORS; k++) begin
                    lo_act[k]   <= lo_sh[k];
                    hi_act[k]   <= hi_sh[k];
                    vmin_act[k] <= vmin_sh[k];
                    shf_act[k]  <= shf_sh[k];
                end
            end
            if (cfg_we) begin
                for (int k = 0; k < NUM_COLORS; k++) begin
                    if (cfg_sel == SW'(k)) begin
                        case (cfg_addr)
                            2'd0:    lo_sh[k]   <= cfg_data[5:0];
                            2'd1:    hi_sh[k]   <= cfg_data[5:0];
                            2'd2:    vmin_sh[k] <= cfg_data;
                            default: shf_sh[k]  <= cfg_data[2:0];
                        endcase
                    end
                end
            end
        end
    end

    logic [7:0] mx_c, mn_c;
    logic [1:0] am_c;

    always_comb begin
        am_c = 2'd0;
        mx_c = i_R;
        if (!(i_R >= i_G && i_R >= i_B)) begin
            if (i_G >= i_B) begin
                am_c = 2'd1;
                mx_c = i_G;
            end else begin
                am_c = 2'd2;
                mx_c = i_B;
            end
        end
        mn_c = i_R;
        if (i_G < mn_c) mn_c = i_G;
        if (i_B < mn_c) mn_c = i_B;
    end

    logic               v1, v2, v3;
    logic [7:0]         r1, g1, b1, r2, g2, b2, r3, g3, b3;
    logic [12:0]        row1, col1, row2, col2, row3, col3;
    logic [7:0]         mx1, mn1;
    logic [1:0]         am1;
    logic [7:0]         d2, val2, d3;
    logic signed [13:0] h2, h3;
    logic signed [13:0] lo3 [NUM_COLORS];
    logic signed [13:0] hi3 [NUM_COLORS];
    logic               vok3[NUM_COLORS];
    logic [7:0]         vsh3[NUM_COLORS];

    logic [7:0]         d_c;
    logic signed [13:0] r_s, g_s, b_s, d_s, h_c;

    always_comb begin
        d_c = mx1 - mn1;
        r_s = $signed({6'd0, r1});
        g_s = $signed({6'd0, g1});
        b_s = $signed({6'd0, b1});
        d_s = $signed({6'd0, d_c});
        case (am1)
            2'd0:    h_c = g_s - b_s;
            2'd1:    h_c = (d_s <<< 1) + (b_s - r_s);
            default: h_c = (d_s <<< 2) + (r_s - g_s);
        endcase
    end

    logic signed [13:0] lo_p [NUM_COLORS];
    logic signed [13:0] hi_p [NUM_COLORS];
    logic signed [13:0] d2_s;

    always_comb begin
        d2_s = $signed({6'd0, d2});
        for (int k = 0; k < NUM_COLORS; k++) begin
            lo_p[k] = $signed({{8{lo_act[k][5]}}, lo_act[k]}) * d2_s;
            hi_p[k] = $signed({{8{hi_act[k][5]}}, hi_act[k]}) * d2_s;
        end
    end

    logic                  win_c;
    logic [NUM_COLORS-1:0] match_c;

    always_comb begin
        win_c = (row3 < 13'(H_ACT)) && (col3 < 13'(W_ACT));
        for (int k = 0; k < NUM_COLORS; k++) begin
            match_c[k] = (lo3[k] < h3) && (h3 < hi3[k]) && vok3[k] && (d3 > vsh3[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {v1, v2, v3, o_valid} <= '0;
            {r1, g1, b1, r2, g2, b2, r3, g3, b3} <= '0;
            {row1, col1, row2, col2, row3, col3} <= '0;
            {mx1, mn1, am1, d2, val2, d3} <= '0;
            h2 <= '0;
            h3 <= '0;
            for (int k = 0; k < NUM_COLORS; k++) begin
                lo3[k]  <= '0;
                hi3[k]  <= '0;
                vok3[k] <= 1'b0;
                vsh3[k] <= '0;
            end
            {o_R, o_G, o_B} <= '0;
            {o_row, o_col}  <= '0;
            o_color         <= '0;
        end else begin
            v1   <= i_valid;
            r1   <= i_R;
            g1   <= i_G;
            b1   <= i_B;
            row1 <= i_row;
            col1 <= i_col;
            mx1  <= mx_c;
            mn1  <= mn_c;
            am1  <= am_c;

            v2   <= v1;
            r2   <= r1;
            g2   <= g1;
            b2   <= b1;
            row2 <= row1;
            col2 <= col1;
            d2   <= d_c;
            val2 <= mx1;
            h2   <= h_c;

            v3   <= v2;
            r3   <= r2;
            g3   <= g2;
            b3   <= b2;
            row3 <= row2;
            col3 <= col2;
            d3   <= d2;
            h3   <= h2;
            for (int k = 0; k < NUM_COLORS; k++) begin
                lo3[k]  <= lo_p[k] >>> 2;
                hi3[k]  <= hi_p[k] >>> 2;
                vok3[k] <= (val2 >= vmin_act[k]);
                vsh3[k] <= val2 >> shf_act[k];
            end

            o_valid <= v3;
            o_row   <= row3;
            o_col   <= col3;
            o_R     <= win_c ? r3 : 8'd0;
            o_G     <= win_c ? g3 : 8'd0;
            o_B     <= win_c ? b3 : 8'd0;
            o_color <= (v3 && win_c) ? match_c : '0;
        end
    end

    logic [CNT_W-1:0] acc_cnt [NUM_COLORS];
    logic [12:0]      acc_rmin[NUM_COLORS];
    logic [12:0]      acc_rmax[NUM_COLORS];
    logic [12:0]      acc_cmin[NUM_COLORS];
    logic [12:0]      acc_cmax[NUM_COLORS];
    logic [CNT_W-1:0] n_cnt   [NUM_COLORS];
    logic [12:0]      n_rmin  [NUM_COLORS];
    logic [12:0]      n_rmax  [NUM_COLORS];
    logic [12:0]      n_cmin  [NUM_COLORS];
    logic [12:0]      n_cmax  [NUM_COLORS];

    assign eof = o_valid && (o_row == 13'(H_ACT - 1)) && (o_col == 13'(W_ACT - 1));

    // Next accumulator values include the current output pixel, so the EOF pixel is counted.
    always_comb begin
        for (int k = 0; k < NUM_COLORS; k++) begin
            n_cnt[k]  = acc_cnt[k];
            n_rmin[k] = acc_rmin[k];
            n_rmax[k] = acc_rmax[k];
            n_cmin[k] = acc_cmin[k];
            n_cmax[k] = acc_cmax[k];
            if (o_valid && o_color[k]) begin
                if (acc_cnt[k] != '1) n_cnt[k] = acc_cnt[k] + CNT_W'(1);
                if (o_row < acc_rmin[k]) n_rmin[k] = o_row;
                if (o_row > acc_rmax[k]) n_rmax[k] = o_row;
                if (o_col < acc_cmin[k]) n_cmin[k] = o_col;
                if (o_col > acc_cmax[k]) n_cmax[k] = o_col;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_valid <= 1'b0;
            for (int k = 0; k < NUM_COLORS; k++) begin
                acc_cnt[k]  <= '0;
                acc_rmin[k] <= COORD_MAX;
                acc_rmax[k] <= '0;
                acc_cmin[k] <= COORD_MAX;
                acc_cmax[k] <= '0;
                stat_count[k*CNT_W +: CNT_W] <= '0;
                stat_rmin[k*13 +: 13] <= COORD_MAX;
                stat_rmax[k*13 +: 13] <= '0;
                stat_cmin[k*13 +: 13] <= COORD_MAX;
                stat_cmax[k*13 +: 13] <= '0;
            end
        end else begin
            stat_valid <= eof;
            for (int k = 0; k < NUM_COLORS; k++) begin
                if (eof) begin
                    stat_count[k*CNT_W +: CNT_W] <= n_cnt[k];
                    stat_rmin[k*13 +: 13] <= n_rmin[k];
                    stat_rmax[k*13 +: 13] <= n_rmax[k];
                    stat_cmin[k*13 +: 13] <= n_cmin[k];
                    stat_cmax[k*13 +: 13] <= n_cmax[k];
                    acc_cnt[k]  <= '0;
                    acc_rmin[k] <= COORD_MAX;
                    acc_rmax[k] <= '0;
                    acc_cmin[k] <= COORD_MAX;
                    acc_cmax[k] <= '0;
                end else begin
                    acc_cnt[k]  <= n_cnt[k];
                    acc_rmin[k] <= n_rmin[k];
                    acc_rmax[k] <= n_rmax[k];
                    acc_cmin[k] <= n_cmin[k];
                    acc_cmax[k] <= n_cmax[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_color_classifier.sv
// Directed bench for rgb_color_classifier; frames are sent sparsely (only the pixels
// that matter plus the (479,639) end-of-frame pixel), since only coordinates mark a frame.
module tb_rgb_color_classifier;

    localparam int NC = 2;
    localparam int CW = 19;

    logic           clk = 1'b0;
    logic           reset;
    logic           i_valid;
    logic [7:0]     i_R, i_G, i_B;
    logic [12:0]    i_row, i_col;
    logic           cfg_we;
    logic [0:0]     cfg_sel;
    logic [1:0]     cfg_addr;
    logic [7:0]     cfg_data;
    logic           o_valid;
    logic [7:0]     o_R, o_G, o_B;
    logic [12:0]    o_row, o_col;
    logic [NC-1:0]  o_color;
    logic           stat_valid;
    logic [NC*CW-1:0] stat_count;
    logic [NC*13-1:0] stat_rmin, stat_rmax, stat_cmin, stat_cmax;

    rgb_color_classifier #(.NUM_COLORS(NC), .H_ACT(480), .W_ACT(640), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid),
        .i_R(i_R), .i_G(i_G), .i_B(i_B), .i_row(i_row), .i_col(i_col),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .o_valid(o_valid), .o_R(o_R), .o_G(o_G), .o_B(o_B), .o_row(o_row), .o_col(o_col),
        .o_color(o_color), .stat_valid(stat_valid), .stat_count(stat_count),
        .stat_rmin(stat_rmin), .stat_rmax(stat_rmax), .stat_cmin(stat_cmin), .stat_cmax(stat_cmax)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    always @(negedge clk) if (stat_valid) pulses++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pix(input logic [7:0] r, g, b, input logic [12:0] row, col);
        i_valid = 1'b1; i_R = r; i_G = g; i_B = b; i_row = row; i_col = col;
        tick();
        i_valid = 1'b0; i_R = '0; i_G = '0; i_B = '0; i_row = '0; i_col = '0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] r, g, b,
                             input logic [12:0] row, col, input logic [NC-1:0] color);
        check({tag, "_valid"}, o_valid, v);
        check({tag, "_color"}, o_color, color);
        check({tag, "_r"}, o_R, r);
        check({tag, "_g"}, o_G, g);
        check({tag, "_b"}, o_B, b);
        check({tag, "_row"}, o_row, row);
        check({tag, "_col"}, o_col, col);
    endtask

    task automatic check_stats(input string tag, input int k, input int cnt,
                               input int rmin, input int rmax, input int cmin, input int cmax);
        check($sformatf("%s_cnt%0d", tag, k), stat_count[k*CW +: CW], cnt);
        check($sformatf("%s_rmin%0d", tag, k), stat_rmin[k*13 +: 13], rmin);
        check($sformatf("%s_rmax%0d", tag, k), stat_rmax[k*13 +: 13], rmax);
        check($sformatf("%s_cmin%0d", tag, k), stat_cmin[k*13 +: 13], cmin);
        check($sformatf("%s_cmax%0d", tag, k), stat_cmax[k*13 +: 13], cmax);
    endtask

    // Sends the EOF pixel and returns in the EOF+1 cycle; optionally writes class-0
    // hue_hi during the EOF cycle itself.
    task automatic end_frame(input string tag, input logic wr, input logic [7:0] wr_data);
        pix(8'd0, 8'd0, 8'd0, 13'd479, 13'd639);
        idle(3);
        check({tag, "_eof_row"}, o_row, 13'd479);
        check({tag, "_sv_early"}, stat_valid, 1'b0);
        if (wr) begin
            cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd1; cfg_data = wr_data;
        end
        tick();
        cfg_we = 1'b0;
        check({tag, "_sv_pulse"}, stat_valid, 1'b1);
    endtask

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_R = '0; i_G = '0; i_B = '0; i_row = '0; i_col = '0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
        idle(3);
        check("rst_ovalid", o_valid, 1'b0);
        check("rst_color", o_color, 2'b00);
        check("rst_or", o_R, 8'd0);
        check("rst_sv", stat_valid, 1'b0);
        check_stats("rst", 0, 0, 8191, 0, 8191, 0);
        reset = 1'b0;
        tick();

        // Back-to-back pixels: red, green, red with H=0, out-of-window row, last in-window row.
        pix(8'd200, 8'd40, 8'd20, 13'd10, 13'd10);
        pix(8'd30, 8'd200, 8'd60, 13'd11, 13'd20);
        pix(8'd200, 8'd20, 8'd20, 13'd12, 13'd20);
        pix(8'd200, 8'd40, 8'd20, 13'd480, 13'd5);
        check_out("red", 1'b1, 8'd200, 8'd40, 8'd20, 13'd10, 13'd10, 2'b01);
        pix(8'd200, 8'd40, 8'd20, 13'd479, 13'd638);
        check_out("green", 1'b1, 8'd30, 8'd200, 8'd60, 13'd11, 13'd20, 2'b10);
        tick();
        check_out("hue0", 1'b1, 8'd200, 8'd20, 8'd20, 13'd12, 13'd20, 2'b00);
        tick();
        check_out("row_out", 1'b1, 8'd0, 8'd0, 8'd0, 13'd480, 13'd5, 2'b00);
        tick();
        check_out("row_edge", 1'b1, 8'd200, 8'd40, 8'd20, 13'd479, 13'd638, 2'b01);
        tick();
        check("bubble_valid", o_valid, 1'b0);
        check("bubble_color", o_color, 2'b00);

        pix(8'd30, 8'd200, 8'd60, 13'd5, 13'd640);
        idle(3);
        check_out("col_out", 1'b1, 8'd0, 8'd0, 8'd0, 13'd5, 13'd640, 2'b00);

        // Clear the partial frame, then a frame with three red pixels.
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("rst2_cnt0", stat_count[CW-1:0], 0);
        pix(8'd200, 8'd40, 8'd20, 13'd10, 13'd10);
        pix(8'd0, 8'd0, 8'd0, 13'd11, 13'd11);
        pix(8'd200, 8'd40, 8'd20, 13'd12, 13'd30);
        idle(2);
        pix(8'd0, 8'd0, 8'd0, 13'd200, 13'd300);
        pix(8'd200, 8'd40, 8'd20, 13'd40, 13'd5);
        pix(8'd0, 8'd0, 8'd0, 13'd478, 13'd639);
        end_frame("f1", 1'b0, 8'd0);
        check_stats("f1", 0, 3, 10, 40, 5, 30);
        check_stats("f1", 1, 0, 8191, 0, 8191, 0);
        tick();
        check("f1_sv_drop", stat_valid, 1'b0);
        check("f1_pulses", pulses, 1);
        check("f1_hold_cnt0", stat_count[CW-1:0], 3);

        // Mid-frame write of class-0 hue_hi=0 affects only the next frame.
        pix(8'd200, 8'd40, 8'd20, 13'd5, 13'd5);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd1; cfg_data = 8'd0;
        tick();
        cfg_we = 1'b0;
        pix(8'd200, 8'd40, 8'd20, 13'd6, 13'd7);
        idle(3);
        check("f2_still_red", o_color, 2'b01);
        end_frame("f2", 1'b1, 8'd1);
        check_stats("f2", 0, 2, 5, 6, 5, 7);

        pix(8'd200, 8'd40, 8'd20, 13'd3, 13'd3);
        idle(3);
        check("f3_red_blocked", o_color, 2'b00);
        check("f3_valid", o_valid, 1'b1);
        end_frame("f3", 1'b0, 8'd0);
        check_stats("f3", 0, 0, 8191, 0, 8191, 0);

        pix(8'd200, 8'd40, 8'd20, 13'd4, 13'd4);
        idle(3);
        check("f4_red_back", o_color, 2'b01);
        end_frame("f4", 1'b0, 8'd0);
        check_stats("f4", 0, 1, 4, 4, 4, 4);
        tick();
        check("f4_pulses", pulses, 4);

        // Reset mid-frame after two counted red pixels.
        pix(8'd200, 8'd40, 8'd20, 13'd1, 13'd1);
        pix(8'd200, 8'd40, 8'd20, 13'd2, 13'd2);
        idle(4);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("rst3_cnt0", stat_count[CW-1:0], 0);
        check("rst3_rmin0", stat_rmin[12:0], 8191);
        check("rst3_sv", stat_valid, 1'b0);
        pix(8'd0, 8'd0, 8'd0, 13'd0, 13'd0);
        pix(8'd200, 8'd40, 8'd20, 13'd20, 13'd21);
        idle(5);
        check("f5_pulses_pre", pulses, 4);
        end_frame("f5", 1'b0, 8'd0);
        check_stats("f5", 0, 1, 20, 20, 21, 21);
        tick();
        check("f5_pulses", pulses, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
